// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined carry adder: default geometry,
// slice-width helper and the per-stage control record.
package adder_pkg;

    localparam int DEFAULT_WIDTH  = 16;
    localparam int DEFAULT_STAGES = 4;

    typedef struct packed {
        logic valid;
        logic carry;
    } stage_ctl_t;

    function automatic int slice_w(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational ripple-carry adder for one SLICE_W-bit slice of the pipeline.
module adder_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] s_o,
    output logic         cout_o
);

    logic [W:0] carryChain;

    always_comb begin
        carryChain    = '0;
        s_o           = '0;
        carryChain[0] = cin_i;
        for (int i = 0; i < W; i++) begin
            s_o[i]          = a_i[i] ^ b_i[i] ^ carryChain[i];
            carryChain[i+1] = (a_i[i] & b_i[i]) | (carryChain[i] & (a_i[i] ^ b_i[i]));
        end
    end

    assign cout_o = carryChain[W];

endmodule

// File: rtl/pipelined_carry_adder.sv
// WIDTH-bit adder split into STAGES registered slices on a valid/ready stream.
// Define PCA_STAGE_CARRY_EN to expose the per-slice carry-outs as stage_carry.
module pipelined_carry_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              cin,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH:0]    sum
`ifdef PCA_STAGE_CARRY_EN
    ,
    output logic [STAGES-1:0] stage_carry
`endif
);

    localparam int SW = slice_w(WIDTH, STAGES);

    if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_badParams
        $error("pipelined_carry_adder: WIDTH (%0d) must be a multiple of STAGES (%0d), 1 <= STAGES <= WIDTH",
               WIDTH, STAGES);
    end

    typedef struct packed {
        stage_ctl_t       ctl;
        logic [WIDTH-1:0] data;
    } stage_t;

    stage_t           stage_q  [STAGES];
    stage_t           stage_d  [STAGES];
    logic [WIDTH-1:0] opA_q    [STAGES];
    logic [WIDTH-1:0] opB_q    [STAGES];

    logic             validIn  [STAGES];
    logic             carryIn  [STAGES];
    logic [WIDTH-1:0] opAIn    [STAGES];
    logic [WIDTH-1:0] opBIn    [STAGES];
    logic [WIDTH-1:0] dataIn   [STAGES];
    logic [SW-1:0]    sliceSum [STAGES];
    logic             sliceCout[STAGES];
    logic             advance;

    // A single enable moves the whole pipeline, bubbles included, so a stall
    // at the output freezes every stage in place.
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign out_valid = stage_q[STAGES-1].ctl.valid;
    assign sum       = {stage_q[STAGES-1].ctl.carry, stage_q[STAGES-1].data};

    always_comb begin
        validIn[0] = in_valid;
        carryIn[0] = cin;
        opAIn[0]   = a;
        opBIn[0]   = b;
        dataIn[0]  = '0;
        for (int k = 1; k < STAGES; k++) begin
            validIn[k] = stage_q[k-1].ctl.valid;
            carryIn[k] = stage_q[k-1].ctl.carry;
            opAIn[k]   = opA_q[k-1];
            opBIn[k]   = opB_q[k-1];
            dataIn[k]  = stage_q[k-1].data;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        adder_slice #(
            .W(SW)
        ) u_slice (
            .a_i    (opAIn[k][k*SW +: SW]),
            .b_i    (opBIn[k][k*SW +: SW]),
            .cin_i  (carryIn[k]),
            .s_o    (sliceSum[k]),
            .cout_o (sliceCout[k])
        );
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            stage_d[k].ctl.valid       = validIn[k];
            stage_d[k].ctl.carry       = sliceCout[k];
            stage_d[k].data            = dataIn[k];
            stage_d[k].data[k*SW +: SW] = sliceSum[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= '0;
                opA_q[k]   <= '0;
                opB_q[k]   <= '0;
            end
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= stage_d[k];
                opA_q[k]   <= opAIn[k];
                opB_q[k]   <= opBIn[k];
            end
        end
    end

`ifdef PCA_STAGE_CARRY_EN
    logic [STAGES-1:0] carryVec_q [STAGES];
    logic [STAGES-1:0] carryVec_d [STAGES];

    // Each stage collects its own slice carry into a vector that travels with
    // the data, so all bits line up with sum at the output.
    always_comb begin
        carryVec_d[0]    = '0;
        carryVec_d[0][0] = sliceCout[0];
        for (int k = 1; k < STAGES; k++) begin
            carryVec_d[k]    = carryVec_q[k-1];
            carryVec_d[k][k] = sliceCout[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                carryVec_q[k] <= '0;
            end
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                carryVec_q[k] <= carryVec_d[k];
            end
        end
    end

    assign stage_carry = carryVec_q[STAGES-1];
`endif

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// Directed and random checks of pipelined_carry_adder (16/4 and 4/1 builds).
module tb_pipelined_carry_adder;

    localparam int W  = 16;
    localparam int S  = 4;
    localparam int W1 = 4;

    logic          clk;
    logic          rst_n;
    logic          inValid;
    logic          inReady;
    logic [W-1:0]  opA;
    logic [W-1:0]  opB;
    logic          carryIn;
    logic          outValid;
    logic          outReady;
    logic [W:0]    sumOut;

    logic          inValid1;
    logic          inReady1;
    logic [W1-1:0] opA1;
    logic [W1-1:0] opB1;
    logic          carryIn1;
    logic          outValid1;
    logic          outReady1;
    logic [W1:0]   sumOut1;

`ifdef PCA_STAGE_CARRY_EN
    logic [S-1:0]  stageCarry;
    logic [0:0]    stageCarry1;
`endif

    typedef struct {
        logic          valid;
        logic [15:0]   a;
        logic [15:0]   b;
        logic          cin;
        logic [16:0]   expSum;
        logic [3:0]    expCarry;
    } vec_t;

    vec_t        vecs [12];
    int          passed;
    int          total;
    int          accepted;
    logic [4:0]  scoreboard [$];

    pipelined_carry_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (inValid),
        .in_ready    (inReady),
        .a           (opA),
        .b           (opB),
        .cin         (carryIn),
        .out_valid   (outValid),
        .out_ready   (outReady),
        .sum         (sumOut)
`ifdef PCA_STAGE_CARRY_EN
        ,
        .stage_carry (stageCarry)
`endif
    );

    pipelined_carry_adder #(.WIDTH(W1), .STAGES(1)) dutSmall (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (inValid1),
        .in_ready    (inReady1),
        .a           (opA1),
        .b           (opB1),
        .cin         (carryIn1),
        .out_valid   (outValid1),
        .out_ready   (outReady1),
        .sum         (sumOut1)
`ifdef PCA_STAGE_CARRY_EN
        ,
        .stage_carry (stageCarry1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual === expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Streams vecs[lo..hi-1] one per cycle and checks each result exactly S cycles later.
    task automatic applyStimulus(input int lo, input int hi);
        int n;
        int idx;
        n = hi - lo;
        for (int m = 0; m <= n + S; m++) begin
            @(negedge clk);
            idx = lo + m - S;
            if (m >= S && m - S < n) begin
                checkOutput($sformatf("vec%0d out_valid", idx), {31'b0, outValid}, {31'b0, vecs[idx].valid});
                if (vecs[idx].valid) begin
                    checkOutput($sformatf("vec%0d sum", idx), {15'b0, sumOut}, {15'b0, vecs[idx].expSum});
`ifdef PCA_STAGE_CARRY_EN
                    checkOutput($sformatf("vec%0d stage_carry", idx), {28'b0, stageCarry}, {28'b0, vecs[idx].expCarry});
`endif
                end
            end else begin
                checkOutput($sformatf("run%0d idle m%0d out_valid", lo, m), {31'b0, outValid}, 32'd0);
            end
            if (m < n) begin
                inValid = vecs[lo+m].valid;
                opA     = vecs[lo+m].a;
                opB     = vecs[lo+m].b;
                carryIn = vecs[lo+m].cin;
            end else begin
                inValid = 1'b0;
            end
        end
    endtask

    initial begin
        passed    = 0;
        total     = 0;
        accepted  = 0;
        rst_n     = 1'b1;
        inValid   = 1'b0;
        opA       = '0;
        opB       = '0;
        carryIn   = 1'b0;
        outReady  = 1'b1;
        inValid1  = 1'b0;
        opA1      = '0;
        opB1      = '0;
        carryIn1  = 1'b0;
        outReady1 = 1'b1;

        vecs[0]  = '{1'b1, 16'hFFFF, 16'h0001, 1'b0, 17'h10000, 4'b1111};
        vecs[1]  = '{1'b1, 16'h000B, 16'h0006, 1'b0, 17'h00011, 4'b0001};
        vecs[2]  = '{1'b1, 16'h0000, 16'h0000, 1'b1, 17'h00001, 4'b0000};
        vecs[3]  = '{1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF, 4'b1111};
        vecs[4]  = '{1'b1, 16'h1234, 16'h4321, 1'b0, 17'h05555, 4'b0000};
        vecs[5]  = '{1'b1, 16'h8000, 16'h8000, 1'b0, 17'h10000, 4'b1000};
        vecs[6]  = '{1'b1, 16'h00FF, 16'h0001, 1'b0, 17'h00100, 4'b0011};
        vecs[7]  = '{1'b1, 16'h0FFF, 16'h0001, 1'b0, 17'h01000, 4'b0111};
        vecs[8]  = '{1'b1, 16'h7FFF, 16'h0001, 1'b1, 17'h08001, 4'b0111};
        vecs[9]  = '{1'b1, 16'h0001, 16'h0002, 1'b0, 17'h00003, 4'b0000};
        vecs[10] = '{1'b0, 16'hAAAA, 16'h5555, 1'b1, 17'h00000, 4'b0000};
        vecs[11] = '{1'b1, 16'hF0F0, 16'h0F10, 1'b0, 17'h10000, 4'b1110};

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset out_valid", {31'b0, outValid}, 32'd0);
        checkOutput("reset sum", {15'b0, sumOut}, 32'd0);
        checkOutput("reset in_ready", {31'b0, inReady}, 32'd1);
        checkOutput("reset small out_valid", {31'b0, outValid1}, 32'd0);
`ifdef PCA_STAGE_CARRY_EN
        checkOutput("reset stage_carry", {28'b0, stageCarry}, 32'd0);
`endif
        rst_n = 1'b1;

        applyStimulus(0, 1);
        applyStimulus(1, 4);
        applyStimulus(4, 9);
        applyStimulus(9, 12);

        // Backpressure: three results queue up behind a stalled consumer.
        for (int m = 0; m < 13; m++) begin
            @(negedge clk);
            if (m < 4 || m >= 11) begin
                checkOutput($sformatf("stall m%0d out_valid", m), {31'b0, outValid}, 32'd0);
            end else if (m <= 8) begin
                checkOutput($sformatf("stall m%0d out_valid", m), {31'b0, outValid}, 32'd1);
                checkOutput($sformatf("stall m%0d sum", m), {15'b0, sumOut}, {15'b0, vecs[1].expSum});
                checkOutput($sformatf("stall m%0d in_ready", m), {31'b0, inReady}, 32'd0);
            end else begin
                checkOutput($sformatf("drain m%0d out_valid", m), {31'b0, outValid}, 32'd1);
                checkOutput($sformatf("drain m%0d sum", m), {15'b0, sumOut}, {15'b0, vecs[m-7].expSum});
            end
            if (m < 3) begin
                inValid = 1'b1;
                opA     = vecs[1+m].a;
                opB     = vecs[1+m].b;
                carryIn = vecs[1+m].cin;
            end else if (m >= 4 && m < 8) begin
                inValid = 1'b1;
                opA     = 16'h5555;
                opB     = 16'h5555;
                carryIn = 1'b1;
            end else begin
                inValid = 1'b0;
            end
            if (m == 0) outReady = 1'b0;
            if (m == 8) outReady = 1'b1;
        end

        // Reset with two results in flight, one already presented.
        for (int m = 0; m < 5; m++) begin
            @(negedge clk);
            if (m < 2) begin
                inValid = 1'b1;
                opA     = vecs[4+m].a;
                opB     = vecs[4+m].b;
                carryIn = vecs[4+m].cin;
            end else begin
                inValid = 1'b0;
            end
        end
        checkOutput("pre-reset out_valid", {31'b0, outValid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midreset out_valid", {31'b0, outValid}, 32'd0);
        checkOutput("midreset sum", {15'b0, sumOut}, 32'd0);
`ifdef PCA_STAGE_CARRY_EN
        checkOutput("midreset stage_carry", {28'b0, stageCarry}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        for (int m = 0; m < S + 2; m++) begin
            @(negedge clk);
            checkOutput($sformatf("post-reset m%0d out_valid", m), {31'b0, outValid}, 32'd0);
        end
        applyStimulus(0, 1);

        // Single-stage, 4-bit build: latency of one cycle.
        @(negedge clk);
        inValid1 = 1'b1;
        opA1     = 4'b1011;
        opB1     = 4'b0110;
        carryIn1 = 1'b0;
        @(negedge clk);
        inValid1 = 1'b0;
        checkOutput("small out_valid", {31'b0, outValid1}, 32'd1);
        checkOutput("small sum", {27'b0, sumOut1}, 32'h11);
`ifdef PCA_STAGE_CARRY_EN
        checkOutput("small stage_carry", {31'b0, stageCarry1}, 32'd1);
`endif
        @(negedge clk);
        checkOutput("small after out_valid", {31'b0, outValid1}, 32'd0);

        // Random stream with random backpressure against a+b+cin.
        for (int cyc = 0; cyc < 6000 && (accepted < 1000 || scoreboard.size() > 0); cyc++) begin
            @(negedge clk);
            inValid1  = (accepted < 1000) && ($urandom_range(0, 3) != 0);
            opA1      = 4'($urandom);
            opB1      = 4'($urandom);
            carryIn1  = 1'($urandom);
            outReady1 = ($urandom_range(0, 3) != 0);
            #1;
            if (outValid1 && outReady1) begin
                if (scoreboard.size() == 0) begin
                    checkOutput("rand spurious out_valid", {31'b0, outValid1}, 32'd0);
                end else begin
                    checkOutput("rand sum", {27'b0, sumOut1}, {27'b0, scoreboard.pop_front()});
                end
            end
            if (inValid1 && inReady1) begin
                scoreboard.push_back({1'b0, opA1} + {1'b0, opB1} + {4'b0, carryIn1});
                accepted++;
            end
        end
        inValid1 = 1'b0;
        checkOutput("rand accepted", accepted, 32'd1000);
        checkOutput("rand drained", scoreboard.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
